// File: rtl/branch_pkg.sv
// Shared constants for branch resolution and prediction: condition codes,
// flag bit positions and 2-bit saturating counter states.
package branch_pkg;

  localparam logic [2:0] COND_NE  = 3'b000;
  localparam logic [2:0] COND_EQ  = 3'b001;
  localparam logic [2:0] COND_GT  = 3'b010;
  localparam logic [2:0] COND_LT  = 3'b011;
  localparam logic [2:0] COND_GE  = 3'b100;
  localparam logic [2:0] COND_LE  = 3'b101;
  localparam logic [2:0] COND_OV  = 3'b110;
  localparam logic [2:0] COND_UNC = 3'b111;

  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 0;

  typedef logic [1:0] sat_cnt_t;

  localparam sat_cnt_t CNT_SNT = 2'b00;
  localparam sat_cnt_t CNT_WNT = 2'b01;
  localparam sat_cnt_t CNT_WT  = 2'b10;
  localparam sat_cnt_t CNT_ST  = 2'b11;

  function automatic sat_cnt_t sat_step(input sat_cnt_t c, input logic up);
    sat_cnt_t r;
    if (up) r = (c == CNT_ST)  ? c : c + 2'd1;
    else    r = (c == CNT_SNT) ? c : c - 2'd1;
    return r;
  endfunction

endpackage

// File: rtl/branch_resolve.sv
// Combinational branch resolver: condition-code decode and target adder.
// Zero latency; no flow control.
module branch_resolve
  import branch_pkg::*;
#(
  parameter int PC_W  = 16,
  parameter int IMM_W = 9
) (
  input  logic [2:0]       cond_i,
  input  logic [2:0]       flags_i,
  input  logic             is_breg_i,
  input  logic [IMM_W-1:0] imm_i,
  input  logic [PC_W-1:0]  pc_i,
  input  logic [PC_W-1:0]  breg_i,
  output logic             taken_o,
  output logic [PC_W-1:0]  target_o
);

  logic            z, v, n;
  logic [PC_W-1:0] offset;

  assign z = flags_i[FLAG_Z];
  assign v = flags_i[FLAG_V];
  assign n = flags_i[FLAG_N];

  always_comb begin
    taken_o = 1'b0;
    case (cond_i)
      COND_NE:  taken_o = ~z;
      COND_EQ:  taken_o = z;
      COND_GT:  taken_o = ~z & ~n;
      COND_LT:  taken_o = n;
      COND_GE:  taken_o = z | ~n;
      COND_LE:  taken_o = z | n;
      COND_OV:  taken_o = v;
      default:  taken_o = 1'b1;
    endcase
  end

  // Immediate counts half-words; sum wraps mod 2^PC_W.
  assign offset   = {{(PC_W-IMM_W){imm_i[IMM_W-1]}}, imm_i} << 1;
  assign target_o = is_breg_i ? breg_i : (pc_i + PC_W'(2) + offset);

endmodule

// File: rtl/branch_predict_unit.sv
// Direct-mapped BTB with 2-bit counters: combinational fetch lookup, EX-stage
// update on resolve, and a registered one-cycle flush/redirect on mispredict.
module branch_predict_unit
  import branch_pkg::*;
#(
  parameter int PC_W    = 16,
  parameter int IMM_W   = 9,
  parameter int ENTRIES = 8,
  parameter int IDX_W   = $clog2(ENTRIES),
  parameter int TAG_W   = PC_W - 1 - IDX_W,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PC_W-1:0]  if_pc,
  output logic             pred_taken,
  output logic [PC_W-1:0]  pred_target,
  output logic [PC_W-1:0]  pred_next_pc,
  input  logic             ex_valid,
  input  logic             ex_is_branch,
  input  logic             ex_is_breg,
  input  logic [2:0]       ex_cond,
  input  logic [2:0]       ex_flags,
  input  logic [IMM_W-1:0] ex_imm,
  input  logic [PC_W-1:0]  ex_pc,
  input  logic [PC_W-1:0]  ex_breg,
  input  logic             ex_pred_taken,
  input  logic [PC_W-1:0]  ex_pred_target,
  output logic             flush,
  output logic [PC_W-1:0]  redirect_pc,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  logic             valid_q [ENTRIES];
  logic [TAG_W-1:0] tag_q   [ENTRIES];
  logic [PC_W-1:0]  tgt_q   [ENTRIES];
  sat_cnt_t         cnt_q   [ENTRIES];

  logic             flush_q, flush_d;
  logic [PC_W-1:0]  redirect_q, redirect_d;
  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

  logic [IDX_W-1:0] if_idx, ex_idx;
  logic [TAG_W-1:0] if_tag, ex_tag;
  logic             if_hit, ex_hit;

  logic             taken;
  logic [PC_W-1:0]  target;
  logic [PC_W-1:0]  seq_pc;
  logic             resolve, mispredict;

  logic             btb_we;
  logic [PC_W-1:0]  tgt_d;
  sat_cnt_t         cnt_d;

  logic             unused_pc_lsb;
  assign unused_pc_lsb = if_pc[0] ^ ex_pc[0];

  // Fetch-side lookup reads the flops directly: a same-cycle update is not bypassed.
  assign if_idx = if_pc[IDX_W:1];
  assign if_tag = if_pc[PC_W-1:IDX_W+1];
  assign if_hit = valid_q[if_idx] && (tag_q[if_idx] == if_tag);

  assign pred_taken   = if_hit & cnt_q[if_idx][1];
  assign pred_target  = if_hit ? tgt_q[if_idx] : '0;
  assign pred_next_pc = pred_taken ? pred_target : (if_pc + PC_W'(2));

  branch_resolve #(
    .PC_W  (PC_W),
    .IMM_W (IMM_W)
  ) u_resolve (
    .cond_i    (ex_cond),
    .flags_i   (ex_flags),
    .is_breg_i (ex_is_breg),
    .imm_i     (ex_imm),
    .pc_i      (ex_pc),
    .breg_i    (ex_breg),
    .taken_o   (taken),
    .target_o  (target)
  );

  assign seq_pc = ex_pc + PC_W'(2);
  assign ex_idx = ex_pc[IDX_W:1];
  assign ex_tag = ex_pc[PC_W-1:IDX_W+1];
  assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

  // The EX instruction during a flush cycle is wrong-path and must not resolve.
  assign resolve    = ex_valid & ex_is_branch & ~flush_q;
  assign mispredict = resolve & ((taken != ex_pred_taken) |
                                 (taken & (target != ex_pred_target)));

  always_comb begin
    flush_d       = mispredict;
    redirect_d    = redirect_q;
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (mispredict) begin
      redirect_d = taken ? target : seq_pc;
    end
    if (resolve && (branch_cnt_q != '1)) begin
      branch_cnt_d = branch_cnt_q + CNT_W'(1);
    end
    if (mispredict && (mispred_cnt_q != '1)) begin
      mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
    end
  end

  // Hits train the counter; taken misses allocate, biased strong for unconditional.
  always_comb begin
    btb_we = resolve & (ex_hit | taken);
    tgt_d  = taken ? target : tgt_q[ex_idx];
    cnt_d  = (ex_cond == COND_UNC) ? CNT_ST : CNT_WT;
    if (ex_hit) begin
      cnt_d = sat_step(cnt_q[ex_idx], taken);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flush_q       <= 1'b0;
      redirect_q    <= '0;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        tgt_q[i]   <= '0;
        cnt_q[i]   <= CNT_WNT;
      end
    end else begin
      flush_q       <= flush_d;
      redirect_q    <= redirect_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
      if (btb_we) begin
        valid_q[ex_idx] <= 1'b1;
        tag_q[ex_idx]   <= ex_tag;
        tgt_q[ex_idx]   <= tgt_d;
        cnt_q[ex_idx]   <= cnt_d;
      end
    end
  end

  assign flush       = flush_q;
  assign redirect_pc = redirect_q;
  assign branch_cnt  = branch_cnt_q;
  assign mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit with hand-computed expectations.
module tb_branch_predict_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] if_pc;
  logic        pred_taken;
  logic [15:0] pred_target, pred_next_pc;
  logic        ex_valid, ex_is_branch, ex_is_breg;
  logic [2:0]  ex_cond, ex_flags;
  logic [8:0]  ex_imm;
  logic [15:0] ex_pc, ex_breg;
  logic        ex_pred_taken;
  logic [15:0] ex_pred_target;
  logic        flush;
  logic [15:0] redirect_pc, branch_cnt, mispred_cnt;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  branch_predict_unit dut (
    .clk            (clk),
    .rst            (rst),
    .if_pc          (if_pc),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .pred_next_pc   (pred_next_pc),
    .ex_valid       (ex_valid),
    .ex_is_branch   (ex_is_branch),
    .ex_is_breg     (ex_is_breg),
    .ex_cond        (ex_cond),
    .ex_flags       (ex_flags),
    .ex_imm         (ex_imm),
    .ex_pc          (ex_pc),
    .ex_breg        (ex_breg),
    .ex_pred_taken  (ex_pred_taken),
    .ex_pred_target (ex_pred_target),
    .flush          (flush),
    .redirect_pc    (redirect_pc),
    .branch_cnt     (branch_cnt),
    .mispred_cnt    (mispred_cnt)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic ex_drive(input logic breg_sel, input logic [2:0] cond, input logic [2:0] flags,
                          input logic [8:0] imm, input logic [15:0] pc, input logic [15:0] breg,
                          input logic ptaken, input logic [15:0] ptarget);
    ex_valid       = 1'b1;
    ex_is_branch   = 1'b1;
    ex_is_breg     = breg_sel;
    ex_cond        = cond;
    ex_flags       = flags;
    ex_imm         = imm;
    ex_pc          = pc;
    ex_breg        = breg;
    ex_pred_taken  = ptaken;
    ex_pred_target = ptarget;
  endtask

  task automatic ex_idle();
    ex_valid     = 1'b0;
    ex_is_branch = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look(input logic [15:0] pc);
    if_pc = pc;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    if_pc = 16'h0000;
    ex_drive(1'b0, 3'b000, 3'b000, 9'h000, 16'h0000, 16'h0000, 1'b0, 16'h0000);
    ex_idle();
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    look(16'h0010);
    chk1 ("rst_pred_taken", pred_taken, 1'b0);
    chk16("rst_pred_target", pred_target, 16'h0000);
    chk16("rst_next_pc", pred_next_pc, 16'h0012);
    chk16("rst_branch_cnt", branch_cnt, 16'h0000);
    chk16("rst_mispred_cnt", mispred_cnt, 16'h0000);
    chk1 ("rst_flush", flush, 1'b0);
    chk16("rst_redirect", redirect_pc, 16'h0000);

    // Taken EQ branch, predicted not-taken: allocate with counter 10
    ex_drive(1'b0, 3'b001, 3'b100, 9'h004, 16'h0020, 16'h0000, 1'b0, 16'h0000);
    tick();
    ex_idle();
    chk1 ("eq_flush", flush, 1'b1);
    chk16("eq_redirect", redirect_pc, 16'h002A);
    tick();
    chk1 ("eq_flush_drop", flush, 1'b0);
    look(16'h0020);
    chk1 ("eq_pred_taken", pred_taken, 1'b1);
    chk16("eq_pred_target", pred_target, 16'h002A);
    chk16("eq_next_pc", pred_next_pc, 16'h002A);
    chk16("eq_mispred_cnt", mispred_cnt, 16'h0001);
    chk16("eq_branch_cnt", branch_cnt, 16'h0001);

    // Alias lookup misses; then not-taken resolve weakens counter 10 -> 01
    look(16'h0030);
    chk1 ("alias_pred_taken", pred_taken, 1'b0);
    chk16("alias_next_pc", pred_next_pc, 16'h0032);
    ex_drive(1'b0, 3'b001, 3'b000, 9'h004, 16'h0020, 16'h0000, 1'b1, 16'h002A);
    tick();
    ex_idle();
    chk1 ("nt_flush", flush, 1'b1);
    chk16("nt_redirect", redirect_pc, 16'h0022);
    tick();
    look(16'h0020);
    chk1 ("nt_pred_taken", pred_taken, 1'b0);
    chk16("nt_pred_target", pred_target, 16'h002A);
    chk16("nt_next_pc", pred_next_pc, 16'h0022);
    chk16("nt_mispred_cnt", mispred_cnt, 16'h0002);

    // Negative offset, correctly predicted; allocation evicts the 0x0020 entry
    ex_drive(1'b0, 3'b111, 3'b000, 9'h1FE, 16'h0040, 16'h0000, 1'b1, 16'h003E);
    tick();
    ex_idle();
    chk1 ("neg_flush", flush, 1'b0);
    chk16("neg_branch_cnt", branch_cnt, 16'h0003);
    chk16("neg_mispred_cnt", mispred_cnt, 16'h0002);
    chk16("neg_redirect_hold", redirect_pc, 16'h0022);
    look(16'h0040);
    chk1 ("neg_pred_taken", pred_taken, 1'b1);
    chk16("neg_pred_target", pred_target, 16'h003E);
    look(16'h0020);
    chk1 ("evict_pred_taken", pred_taken, 1'b0);
    chk16("evict_pred_target", pred_target, 16'h0000);

    // Target wrap-around
    ex_drive(1'b0, 3'b111, 3'b000, 9'h002, 16'hFFFC, 16'h0000, 1'b1, 16'h0002);
    tick();
    ex_idle();
    chk1 ("wrap_flush", flush, 1'b0);
    chk16("wrap_branch_cnt", branch_cnt, 16'h0004);
    look(16'hFFFC);
    chk1 ("wrap_pred_taken", pred_taken, 1'b1);
    chk16("wrap_next_pc", pred_next_pc, 16'h0002);

    // BR with wrong predicted target; a mispredicting branch in the flush cycle is ignored
    ex_drive(1'b1, 3'b111, 3'b000, 9'h000, 16'h0050, 16'h1234, 1'b1, 16'h1000);
    tick();
    ex_drive(1'b0, 3'b111, 3'b000, 9'h000, 16'h0060, 16'h0000, 1'b0, 16'h0000);
    chk1 ("br_flush", flush, 1'b1);
    chk16("br_redirect", redirect_pc, 16'h1234);
    chk16("br_branch_cnt", branch_cnt, 16'h0005);
    chk16("br_mispred_cnt", mispred_cnt, 16'h0003);
    tick();
    ex_idle();
    chk1 ("shadow_flush", flush, 1'b0);
    chk16("shadow_branch_cnt", branch_cnt, 16'h0005);
    chk16("shadow_mispred_cnt", mispred_cnt, 16'h0003);
    chk16("shadow_redirect", redirect_pc, 16'h1234);
    look(16'h0060);
    chk1 ("shadow_no_alloc", pred_taken, 1'b0);
    look(16'h0050);
    chk1 ("br_pred_taken", pred_taken, 1'b1);
    chk16("br_pred_target", pred_target, 16'h1234);

    // Reset asserted during a flush cycle
    ex_drive(1'b0, 3'b111, 3'b000, 9'h000, 16'h0070, 16'h0000, 1'b0, 16'h0000);
    tick();
    chk1 ("pre_rst_flush", flush, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ex_idle();
    chk1 ("post_rst_flush", flush, 1'b0);
    chk16("post_rst_redirect", redirect_pc, 16'h0000);
    chk16("post_rst_branch_cnt", branch_cnt, 16'h0000);
    chk16("post_rst_mispred_cnt", mispred_cnt, 16'h0000);
    look(16'h0050);
    chk1 ("post_rst_miss_0050", pred_taken, 1'b0);
    look(16'h0040);
    chk1 ("post_rst_miss_0040", pred_taken, 1'b0);
    look(16'hFFFC);
    chk1 ("post_rst_miss_fffc", pred_taken, 1'b0);
    chk16("post_rst_target_fffc", pred_target, 16'h0000);
    look(16'h0070);
    chk1 ("post_rst_miss_0070", pred_taken, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
